// File: rtl/pipe_pkg.sv
// Shared ALU operation classes, R-type function codes and datapath width
// for the MIPS-subset pipeline stages.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_OR    = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_SLT   = 2'b11
  } alu_op_e;

  typedef enum logic [5:0] {
    F_SLL = 6'b000000,
    F_SRL = 6'b000010,
    F_ADD = 6'b100000,
    F_SUB = 6'b100010,
    F_AND = 6'b100100,
    F_OR  = 6'b100101,
    F_SLT = 6'b101010
  } funct_e;

endpackage

// File: rtl/exe_wb_stage_if.sv
// ID/EXE-to-EXE/WB bus: decoded EXE_* fields in, registered WB_* results and
// the retired-write counter out.
interface exe_wb_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic [5:0]        EXE_opcode;
  logic [4:0]        EXE_rs_addr;
  logic [4:0]        EXE_rt_addr;
  logic [4:0]        EXE_rd_addr;
  logic [4:0]        EXE_shamt;
  logic [5:0]        EXE_funct;
  logic [DATA_W-1:0] EXE_immd;
  logic              EXE_RegWrite;
  logic              EXE_RegDst;
  logic [1:0]        EXE_ALUOp;
  logic              EXE_ALUSrc;

  logic [DATA_W-1:0] WB_result;
  logic [4:0]        WB_wr_addr;
  logic              WB_RegWrite;
  logic [31:0]       retire_cnt;

  modport master (
    output EXE_opcode, EXE_rs_addr, EXE_rt_addr, EXE_rd_addr, EXE_shamt,
           EXE_funct, EXE_immd, EXE_RegWrite, EXE_RegDst, EXE_ALUOp, EXE_ALUSrc,
    input  WB_result, WB_wr_addr, WB_RegWrite, retire_cnt
  );

  modport slave (
    input  EXE_opcode, EXE_rs_addr, EXE_rt_addr, EXE_rd_addr, EXE_shamt,
           EXE_funct, EXE_immd, EXE_RegWrite, EXE_RegDst, EXE_ALUOp, EXE_ALUSrc,
    output WB_result, WB_wr_addr, WB_RegWrite, retire_cnt
  );
endinterface

// File: rtl/exe_wb_stage_alu.sv
// Combinational ALU; valid_op drops for unsupported R-type function codes so
// the stage can suppress the register write.
module alu
  import pipe_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] rt_val,
  input  logic [4:0]   shamt,
  input  logic [1:0]   ALUOp,
  input  logic [5:0]   funct,
  output logic [W-1:0] result,
  output logic         valid_op
);

  always_comb begin
    result   = '0;
    valid_op = 1'b1;
    case (ALUOp)
      ALU_ADD:   result = A + B;
      ALU_OR:    result = A | B;
      ALU_SLT:   result = W'($signed(A) < $signed(B));
      ALU_RTYPE: begin
        case (funct)
          F_ADD:   result = A + B;
          F_SUB:   result = A - B;
          F_AND:   result = A & B;
          F_OR:    result = A | B;
          F_SLT:   result = W'($signed(A) < $signed(B));
          // Shifts take their operand from rt regardless of ALUSrc.
          F_SLL:   result = rt_val << shamt;
          F_SRL:   result = rt_val >> shamt;
          default: valid_op = 1'b0;
        endcase
      end
      default: valid_op = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_wb_stage.sv
// EXE/WB stage: register file, WB-to-EXE forwarding, ALU, EXE/WB register
// and retired-write counter. EXE_opcode is not used by the datapath.
module exe_wb_stage #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned NREG   = 32
) (
  input  logic          clk,
  input  logic          rst,
  exe_wb_stage_if.slave bus
);
  import pipe_pkg::*;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rf_rs, rf_rt, op_a, rt_val, op_b, alu_res;
  logic [4:0]        dst_addr;
  logic              valid_op, wb_fire, fwd_rs, fwd_rt;

  assign rf_rs = (bus.EXE_rs_addr == '0) ? '0 : regs[bus.EXE_rs_addr];
  assign rf_rt = (bus.EXE_rt_addr == '0) ? '0 : regs[bus.EXE_rt_addr];

  // The instruction in WB has not reached the register file yet.
  assign wb_fire = bus.WB_RegWrite && (bus.WB_wr_addr != '0);
  assign fwd_rs  = wb_fire && (bus.WB_wr_addr == bus.EXE_rs_addr);
  assign fwd_rt  = wb_fire && (bus.WB_wr_addr == bus.EXE_rt_addr);

  assign op_a     = fwd_rs ? bus.WB_result : rf_rs;
  assign rt_val   = fwd_rt ? bus.WB_result : rf_rt;
  assign op_b     = bus.EXE_ALUSrc ? bus.EXE_immd : rt_val;
  assign dst_addr = bus.EXE_RegDst ? bus.EXE_rd_addr : bus.EXE_rt_addr;

  alu #(.W(DATA_W)) u_alu (
    .A        (op_a),
    .B        (op_b),
    .rt_val   (rt_val),
    .shamt    (bus.EXE_shamt),
    .ALUOp    (bus.EXE_ALUOp),
    .funct    (bus.EXE_funct),
    .result   (alu_res),
    .valid_op (valid_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      bus.WB_result   <= '0;
      bus.WB_wr_addr  <= '0;
      bus.WB_RegWrite <= 1'b0;
      bus.retire_cnt  <= '0;
    end else begin
      if (wb_fire) begin
        regs[bus.WB_wr_addr] <= bus.WB_result;
        bus.retire_cnt       <= bus.retire_cnt + 32'd1;
      end
      bus.WB_result   <= alu_res;
      bus.WB_wr_addr  <= dst_addr;
      bus.WB_RegWrite <= bus.EXE_RegWrite && valid_op;
    end
  end

endmodule
